filtez: RTL and testbench

FILTEZ -- requirements
Module: filtez

---
 rtl/adpcm_pkg.sv | 17 +
 rtl/filtez_mac.sv | 41 ++++
 rtl/filtez.sv | 118 +++++++++++
 tb/tb_filtez.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/adpcm_pkg.sv
// Shared ADPCM constants: zero-predictor tap count, output scaling shift,
// coefficient/delay-line address width and the FILTEZ state encoding.
package adpcm_pkg;

    localparam int N_TAPS    = 6;
    localparam int SZL_SHIFT = 14;
    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 32;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_FETCH = 4'b0010,
        ST_LAST  = 4'b0100,
        ST_DONE  = 4'b1000
    } state_t;

endpackage

// File: rtl/filtez_mac.sv
// Signed 32x32 multiply-accumulate into a wrapping ACC_W-bit accumulator.
// clr has priority over en; sum exposes the value the next enabled edge would load.
module filtez_mac
    import adpcm_pkg::*;
#(
    parameter int ACC_W = 64
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  sum
);

    logic signed [ACC_W-1:0]    acc;
    logic signed [2*DATA_W-1:0] a_ext;
    logic signed [2*DATA_W-1:0] b_ext;
    logic signed [2*DATA_W-1:0] prod;

    // The low 64 bits of a 64x64 product of sign-extended operands equal the full 32x32 product.
    always_comb begin
        a_ext = {{DATA_W{a[DATA_W-1]}}, a};
        b_ext = {{DATA_W{b[DATA_W-1]}}, b};
        prod  = a_ext * b_ext;
        sum   = acc + ACC_W'(prod);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/filtez.sv
// ADPCM zero-predictor: szl = (sum of bli[i]*dlti[i], i=0..5) >>> 14, read from two
// single-port ROM-style memories with one-cycle read latency.
module filtez
    import adpcm_pkg::*;
#(
    parameter int N_TAPS = adpcm_pkg::N_TAPS,
    parameter int ACC_W  = 64
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    output logic [ADDR_W-1:0] bli_address0,
    output logic              bli_ce0,
    input  logic [DATA_W-1:0] bli_q0,
    output logic [ADDR_W-1:0] dlti_address0,
    output logic              dlti_ce0,
    input  logic [DATA_W-1:0] dlti_q0,
    output logic [DATA_W-1:0] ap_return
);

    state_t              state, state_d;
    logic [ADDR_W-1:0]   idx, idx_d;
    logic                mac_clr;
    logic                mac_en;
    logic                ret_load;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic signed [ACC_W-1:0] mac_sum;

    filtez_mac #(
        .ACC_W (ACC_W)
    ) u_mac (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clr      (mac_clr),
        .en       (mac_en),
        .a        (bli_q0),
        .b        (dlti_q0),
        .sum      (mac_sum)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_d;
            idx   <= idx_d;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d  = state;
        idx_d    = idx;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        ret_load = 1'b0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        ap_idle  = 1'b0;
        ap_done  = 1'b0;
        ap_ready = 1'b0;

        unique case (state)
            ST_IDLE: begin
                ap_idle = !ap_start;
                if (ap_start) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                    mac_clr = 1'b1;
                end
            end
            ST_FETCH: begin
                // Read data trails the address by one cycle, so the first fetch has nothing to add.
                rd_en   = 1'b1;
                rd_addr = idx;
                mac_en  = (idx != '0);
                idx_d   = idx + 1'b1;
                if (idx == ADDR_W'(N_TAPS - 1)) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                mac_en   = 1'b1;
                ret_load = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bli_ce0       = rd_en;
    assign dlti_ce0      = rd_en;
    assign bli_address0  = rd_addr;
    assign dlti_address0 = rd_addr;

    // The result is captured from the final sum on the edge entering DONE, so it is
    // already valid while ap_done is high and then holds until the next evaluation.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ap_return <= '0;
        end else if (ret_load) begin
            ap_return <= DATA_W'(mac_sum >>> SZL_SHIFT);
        end
    end

endmodule

// File: tb/tb_filtez.sv
// Directed bench for filtez: behavioural coefficient/delay-line memories,
// hand-computed results, latency, address sequence and reset behaviour.
module tb_filtez;

    logic        ap_clk;
    logic        ap_rst_n;
    logic        ap_start;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_ready;
    logic [2:0]  bli_address0;
    logic        bli_ce0;
    logic [31:0] bli_q0;
    logic [2:0]  dlti_address0;
    logic        dlti_ce0;
    logic [31:0] dlti_q0;
    logic [31:0] ap_return;

    logic [31:0] bli_mem  [0:7];
    logic [31:0] dlti_mem [0:7];

    int errors = 0;
    int checks = 0;

    filtez #(
        .N_TAPS (6),
        .ACC_W  (64)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .ap_start      (ap_start),
        .ap_done       (ap_done),
        .ap_idle       (ap_idle),
        .ap_ready      (ap_ready),
        .bli_address0  (bli_address0),
        .bli_ce0       (bli_ce0),
        .bli_q0        (bli_q0),
        .dlti_address0 (dlti_address0),
        .dlti_ce0      (dlti_ce0),
        .dlti_q0       (dlti_q0),
        .ap_return     (ap_return)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) begin
        if (bli_ce0)  bli_q0  <= bli_mem[bli_address0];
        if (dlti_ce0) dlti_q0 <= dlti_mem[dlti_address0];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [31:0] bv, input logic [31:0] dv);
        for (int i = 0; i < 8; i++) begin
            bli_mem[i]  = bv;
            dlti_mem[i] = dv;
        end
    endtask

    // Starts one evaluation (caller is at a negedge) and follows it until ap_done.
    // lat is the number of negedges from the start request to the ap_done sample.
    task automatic run_eval(input bit keep_start, output int lat, output logic [31:0] ret,
                            output logic [31:0] early_ret, output int naddr,
                            output bit addr_ok, output bit ready_ok);
        lat       = 0;
        ret       = '0;
        early_ret = '0;
        naddr     = 0;
        addr_ok   = 1'b1;
        ready_ok  = 1'b0;
        ap_start  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge ap_clk);
            if (!keep_start) ap_start = 1'b0;
            if (c == 1) early_ret = ap_return;
            if (bli_ce0) begin
                if (!dlti_ce0 || bli_address0 != naddr[2:0] || dlti_address0 != naddr[2:0])
                    addr_ok = 1'b0;
                naddr++;
            end else if (dlti_ce0 || bli_address0 != 3'd0 || dlti_address0 != 3'd0) begin
                addr_ok = 1'b0;
            end
            if (ap_done) begin
                lat      = c;
                ret      = ap_return;
                ready_ok = ap_ready;
                break;
            end
        end
    endtask

    int          lat;
    logic [31:0] ret;
    logic [31:0] early;
    int          naddr;
    bit          addr_ok;
    bit          ready_ok;
    int          done_seen;

    initial begin
        ap_rst_n = 1'b0;
        ap_start = 1'b0;
        fill(32'd0, 32'd0);
        #12;
        check("rst_idle",    32'(ap_idle),  32'd1);
        check("rst_done",    32'(ap_done),  32'd0);
        check("rst_ready",   32'(ap_ready), 32'd0);
        check("rst_ce",      32'({bli_ce0, dlti_ce0}), 32'd0);
        check("rst_addr",    32'({bli_address0, dlti_address0}), 32'd0);
        check("rst_return",  ap_return, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // All coefficients zero, delay line arbitrary.
        fill(32'd0, 32'd0);
        for (int i = 0; i < 6; i++) dlti_mem[i] = 32'h1234_5678 + 32'(i * 977);
        run_eval(1'b0, lat, ret, early, naddr, addr_ok, ready_ok);
        check("zero_ret",     ret, 32'd0);
        check("zero_latency", 32'(lat + 1), 32'd9);
        check("zero_naddr",   32'(naddr), 32'd6);
        check("zero_addrseq", 32'(addr_ok), 32'd1);
        check("zero_ready",   32'(ready_ok), 32'd1);
        @(negedge ap_clk);
        check("zero_done_1cyc", 32'(ap_done), 32'd0);
        check("zero_idle_after", 32'(ap_idle), 32'd1);

        // bli=16384, dlti=1: 6*16384 >>> 14 = 6.
        fill(32'd16384, 32'd1);
        run_eval(1'b0, lat, ret, early, naddr, addr_ok, ready_ok);
        check("unit_ret",     ret, 32'd6);
        check("unit_latency", 32'(lat), 32'd8);
        check("unit_hold_on_start", early, 32'd0);
        @(negedge ap_clk);

        // Mixed taps: 16384-32768+98304+0+40960+6 = 122886 -> 7.
        fill(32'd0, 32'd0);
        bli_mem[0] = 32'd16384;  dlti_mem[0] = 32'd1;
        bli_mem[1] = -32'sd16384; dlti_mem[1] = 32'd2;
        bli_mem[2] = 32'd32768;  dlti_mem[2] = 32'd3;
        bli_mem[3] = 32'd0;      dlti_mem[3] = 32'd4;
        bli_mem[4] = 32'd8192;   dlti_mem[4] = 32'd5;
        bli_mem[5] = 32'd1;      dlti_mem[5] = 32'd6;
        run_eval(1'b0, lat, ret, early, naddr, addr_ok, ready_ok);
        check("mixed_ret",     ret, 32'd7);
        check("mixed_addrseq", 32'(addr_ok), 32'd1);
        check("mixed_hold_on_start", early, 32'd6);
        repeat (4) @(negedge ap_clk);
        check("mixed_hold_idle", ap_return, 32'd7);

        // Single negative tap: -32768*3 = -98304 -> -6.
        fill(32'd0, 32'd0);
        bli_mem[0]  = -32'sd32768;
        dlti_mem[0] = 32'd3;
        run_eval(1'b0, lat, ret, early, naddr, addr_ok, ready_ok);
        check("neg_ret", ret, 32'hFFFF_FFFA);
        @(negedge ap_clk);

        // Max positive everywhere: acc wraps to 0x7FFFFFFA00000006, bits [45:14] = 0xFFE80000.
        fill(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_eval(1'b0, lat, ret, early, naddr, addr_ok, ready_ok);
        check("wrap_ret", ret, 32'hFFE8_0000);
        @(negedge ap_clk);

        // ap_start held high across two back-to-back evaluations with different data.
        fill(32'd16384, 32'd1);
        run_eval(1'b1, lat, ret, early, naddr, addr_ok, ready_ok);
        check("b2b_first_ret",   ret, 32'd6);
        check("b2b_first_naddr", 32'(naddr), 32'd6);
        check("b2b_first_hold",  early, 32'hFFE8_0000);
        fill(32'd0, 32'd0);
        bli_mem[0]  = -32'sd32768;
        dlti_mem[0] = 32'd3;
        run_eval(1'b1, lat, ret, early, naddr, addr_ok, ready_ok);
        ap_start = 1'b0;
        check("b2b_spacing",      32'(lat), 32'd9);
        check("b2b_second_ret",   ret, 32'hFFFF_FFFA);
        check("b2b_second_naddr", 32'(naddr), 32'd6);
        check("b2b_second_addr",  32'(addr_ok), 32'd1);
        check("b2b_early_ret",    early, 32'd6);
        @(negedge ap_clk);

        // Reset in the third FETCH cycle abandons the run; a restart is correct.
        fill(32'd16384, 32'd1);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        @(negedge ap_clk);
        @(negedge ap_clk);
        check("rst_mid_fetching", 32'({bli_ce0, bli_address0}), 32'h0A);
        ap_rst_n = 1'b0;
        #1;
        check("rst_mid_ce",     32'({bli_ce0, dlti_ce0}), 32'd0);
        check("rst_mid_addr",   32'({bli_address0, dlti_address0}), 32'd0);
        check("rst_mid_return", ap_return, 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge ap_clk);
            if (ap_done) done_seen++;
        end
        check("rst_mid_no_done", 32'(done_seen), 32'd0);
        run_eval(1'b0, lat, ret, early, naddr, addr_ok, ready_ok);
        check("rst_restart_ret",     ret, 32'd6);
        check("rst_restart_latency", 32'(lat), 32'd8);
        @(negedge ap_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
